bsg_credit_pool_arbiter: RTL and testbench
==========================================

Name: bsg_credit_pool_arbiter

Overview:
- Shares one up/down credit counter among els_p requesters using round-robin arbitration.
- A requester asks for a variable number of credits (0..max_step_p). It is granted only if the pool holds enough credits.
- Consumers return credits in variable steps.
- Head-of-line reservation guarantees that large requests cannot be starved by small ones. The block sits in front of shared buffer or FIFO space allocation.

Parameters:
els_p, 4, number of requesters
max_step_p, 2, maximum credits requested or returned per cycle
credits_p, 10, initial and maximum credit count
step_width (derived), clog2(max_step_p+1), width of a cost or return field
credit_width (derived), clog2(credits_p+1), width of the credit count

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  reset, asynchronous active-low
v_i  in  els_p  per-requester request valid
cost_i  in  els_p*step_width  per-requester credit cost; slot i is bits [i*step_width +: step_width]
yumi_o  out  els_p  one-hot grant; the request is consumed this cycle
return_i  in  step_width  credits returned this cycle
credits_o  out  credit_width  registered current credit count
reserved_o  out  1  high while in RESERVE state
err_o  out  1  sticky error flag

Behaviour:
- Reset is one clock with asynchronous, active-low reset. While reset_n_i is low:
  - credits_o=credits_p, rr pointer=0, state=IDLE, reserved_o=0, err_o=0.
  - yumi_o=0, forced combinationally.
- Requester protocol:
  - Once v_i[i] rises, it and cost_i slot i hold stable until yumi_o[i] is seen.
  - Dropping v_i before grant is a protocol violation. The block sets err_o and, if it was the reserved requester, returns to IDLE.
- Arbitration (combinational from registered state):
  - At most one yumi_o bit per cycle. Grant has 0-cycle latency: yumi_o is asserted in the same cycle as v_i when the request is grantable.
  - IDLE: candidate = first i with v_i[i]=1, scanning from ptr upward with wrap-around. If cost(candidate) <= credits_o, assert yumi_o[candidate]. Otherwise grant nothing and go to RESERVE, latching res_id=candidate.
  - RESERVE: only res_id is considered; all other requesters are blocked. When cost(res_id) <= credits_o, assert yumi_o[res_id] and go to IDLE.
  - After any grant, ptr <= winner+1 mod els_p. ptr does not change in cycles without a grant.
- Credit arithmetic:
  - Compare only against the registered credits_o. A same-cycle return_i is not usable until the next cycle.
  - next = credits_o - granted_cost + return_i, computed at credit_width+1 bits.
  - If next > credits_p: credits_o <= credits_p (saturate) and err_o <= 1.
  - Underflow cannot occur, because a grant requires cost <= credits_o.
  - Simultaneous grant and return are both applied in the same update.
- Cost rules:
  - Cost 0 is always grantable and consumes nothing.
  - Cost > max_step_p: err_o <= 1, and the request is treated as cost max_step_p for both compare and subtract.
  - return_i > max_step_p: err_o <= 1, and the return is clamped to max_step_p.
- err_o clears only on reset.
- Reset asserted mid-RESERVE: the state is abandoned immediately and the counter is restored to credits_p.

Test Plan:
- Reset then idle, no requests, return_i=0 -> credits_o=10, yumi_o=0, reserved_o=0, err_o=0.
- All four request with cost 1, return_i=0 -> grants in order 0,1,2,3,0,... one per cycle; credits_o goes 9,8,...; once credits_o=0 the next requester is held in RESERVE.
- credits_o=1, req0 cost 2, req1 cost 1, ptr=0 -> RESERVE on req0 and req1 is blocked. After one cycle with return_i=1, credits_o=2; req0 is then granted, credits_o=0, state returns to IDLE, ptr=1.
- credits_o=5, grant of cost 2 with return_i=2 in the same cycle -> credits_o=5 next cycle; yumi_o is asserted in the request cycle.
- credits_o=10, return_i=1 -> credits_o stays 10, err_o=1 and remains set.
- Assert reset_n_i low asynchronously mid-RESERVE with credits_o=1 -> credits_o=10, reserved_o=0 and yumi_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bsg_credit_pool_arbiter_if.sv
// ============================================================================
// Module      : bsg_credit_pool_arbiter_if
// Description : Request/grant bundle for the credit pool arbiter. Carries
//               the per-requester valid and cost, the one-hot grant
//               (yumi), and the per-cycle credit return.
// Ports       : v_i      - per-requester request valid
//               cost_i   - packed per-requester cost, slot i at
//                          [i*step_width +: step_width]
//               yumi_o   - one-hot grant, request consumed this cycle
//               return_i - credits returned this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bsg_credit_pool_arbiter_if #(
  parameter int els_p      = 4,
  parameter int max_step_p = 2
);
  localparam int step_width = $clog2(max_step_p + 1);

  logic [els_p-1:0]            v_i;
  logic [els_p*step_width-1:0] cost_i;
  logic [els_p-1:0]            yumi_o;
  logic [step_width-1:0]       return_i;

  // Requester/consumer side
  modport master (output v_i, cost_i, return_i, input yumi_o);
  // Arbiter side
  modport slave  (input v_i, cost_i, return_i, output yumi_o);
endinterface

`default_nettype wire

// File: rtl/bsg_credit_pool_arbiter.sv
// ============================================================================
// Module      : bsg_credit_pool_arbiter
// Description : Round-robin arbiter sharing one up/down credit pool among
//               els_p requesters. A requester whose cost exceeds the pool
//               is reserved (head-of-line) so smaller requests cannot
//               starve it.
// Ports       : clk_i      - clock, rising edge
//               reset_n_i  - asynchronous active-low reset
//               req_if     - request/grant/return bundle (slave modport)
//               credits_o  - registered credit count
//               reserved_o - high while a reservation is held
//               err_o      - sticky error flag (cleared only by reset)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_credit_pool_arbiter #(
  parameter int els_p      = 4,
  parameter int max_step_p = 2,
  parameter int credits_p  = 10
) (
  input  wire logic                           clk_i,
  input  wire logic                           reset_n_i,
  bsg_credit_pool_arbiter_if.slave            req_if,
  output logic [$clog2(credits_p+1)-1:0]      credits_o,
  output logic                                reserved_o,
  output logic                                err_o
);

  localparam int step_width   = $clog2(max_step_p + 1);
  localparam int credit_width = $clog2(credits_p + 1);
  localparam int ptr_width    = (els_p > 1) ? $clog2(els_p) : 1;

  localparam logic [step_width-1:0]   c_max_step    = step_width'(max_step_p);
  localparam logic [credit_width:0]   c_credits_ext = (credit_width+1)'(credits_p);
  localparam logic [ptr_width-1:0]    c_last_id     = ptr_width'(els_p - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RESERVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ptr_width-1:0]    ptr_q, ptr_d;
  logic [ptr_width-1:0]    res_id_q, res_id_d;
  logic [credit_width-1:0] credits_q, credits_d;
  logic                    err_q, err_d;
  logic [els_p-1:0]        pend_q, pend_d;

  logic [step_width-1:0]   cost_eff [els_p];
  logic [els_p-1:0]        cost_over;
  logic [step_width-1:0]   ret_eff;
  logic                    ret_over;
  logic [els_p-1:0]        drop;
  logic                    cand_found;
  logic [ptr_width-1:0]    cand_id;
  logic [els_p-1:0]        yumi_raw;
  logic [step_width-1:0]   grant_cost;
  logic [credit_width:0]   sum;
  logic                    sat;

  // Oversized costs are clamped so compare and subtract use the same value.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_cost
    logic [step_width-1:0] raw;
    assign raw           = req_if.cost_i[gi*step_width +: step_width];
    assign cost_over[gi] = req_if.v_i[gi] && (raw > c_max_step);
    assign cost_eff[gi]  = (raw > c_max_step) ? c_max_step : raw;
  end

  assign ret_over = req_if.return_i > c_max_step;
  assign ret_eff  = ret_over ? c_max_step : req_if.return_i;

  // A request seen last cycle and not granted must still be present.
  assign drop = pend_q & ~req_if.v_i;

  // Round-robin candidate: first valid requester at or after ptr_q.
  always_comb begin
    int idx;
    idx        = 0;
    cand_found = 1'b0;
    cand_id    = '0;
    for (int k = 0; k < els_p; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= els_p) idx = idx - els_p;
      if (!cand_found && req_if.v_i[idx]) begin
        cand_found = 1'b1;
        cand_id    = ptr_width'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    res_id_d   = res_id_q;
    ptr_d      = ptr_q;
    yumi_raw   = '0;
    grant_cost = '0;
    case (state_q)
      IDLE: begin
        if (cand_found) begin
          if (credit_width'(cost_eff[cand_id]) <= credits_q) begin
            yumi_raw[cand_id] = 1'b1;
            grant_cost        = cost_eff[cand_id];
            ptr_d             = (cand_id == c_last_id) ? '0 : cand_id + ptr_width'(1);
          end else begin
            state_d  = RESERVE;
            res_id_d = cand_id;
          end
        end
      end
      RESERVE: begin
        // Reserved requester withdrew: release the reservation.
        if (drop[res_id_q]) begin
          state_d = IDLE;
        end else if (req_if.v_i[res_id_q] &&
                     (credit_width'(cost_eff[res_id_q]) <= credits_q)) begin
          yumi_raw[res_id_q] = 1'b1;
          grant_cost         = cost_eff[res_id_q];
          ptr_d              = (res_id_q == c_last_id) ? '0 : res_id_q + ptr_width'(1);
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One extra bit holds the overshoot when returns exceed the pool size.
  assign sum       = {1'b0, credits_q} - (credit_width+1)'(grant_cost)
                     + (credit_width+1)'(ret_eff);
  assign sat       = sum > c_credits_ext;
  assign credits_d = sat ? credit_width'(credits_p) : sum[credit_width-1:0];
  assign err_d     = err_q | ret_over | (|cost_over) | (|drop) | sat;
  assign pend_d    = req_if.v_i & ~yumi_raw;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      res_id_q  <= '0;
      credits_q <= credit_width'(credits_p);
      err_q     <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      res_id_q  <= res_id_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  // Grants are suppressed the moment reset asserts, not at the next edge.
  assign req_if.yumi_o = reset_n_i ? yumi_raw : '0;
  assign credits_o     = credits_q;
  assign reserved_o    = (state_q == RESERVE);
  assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bsg_credit_pool_arbiter.sv
// ============================================================================
// Module      : tb_bsg_credit_pool_arbiter
// Description : Self-checking bench for bsg_credit_pool_arbiter (els_p=4,
//               max_step_p=2, credits_p=10) with a reference model feeding
//               a scoreboard of expected grants and post-edge state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_credit_pool_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] credits;
  logic       reserved;
  logic       err;

  bsg_credit_pool_arbiter_if #(.els_p(4), .max_step_p(2)) bus ();

  bsg_credit_pool_arbiter #(.els_p(4), .max_step_p(2), .credits_p(10)) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .req_if     (bus),
    .credits_o  (credits),
    .reserved_o (reserved),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] yumi;
    logic [3:0] credits;
    logic       res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model state
  int         m_credits;
  int         m_ptr;
  logic       m_res;
  int         m_resid;
  logic       m_err;
  logic [3:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [7:0] r;
    r = {2'(c3), 2'(c2), 2'(c1), 2'(c0)};
    return r;
  endfunction

  task automatic model_reset();
    m_credits = 10; m_ptr = 0; m_res = 1'b0; m_resid = 0; m_err = 1'b0; m_pend = '0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [7:0] cost,
                            input logic [1:0] ret, output logic [3:0] y);
    int cst[4];
    int r, cand, gc, nxt;
    logic [3:0] dr;
    y  = '0;
    gc = 0;
    for (int i = 0; i < 4; i++) begin
      cst[i] = int'(cost[2*i +: 2]);
      if (cst[i] > 2) begin
        if (v[i]) m_err = 1'b1;
        cst[i] = 2;
      end
    end
    r = int'(ret);
    if (r > 2) begin m_err = 1'b1; r = 2; end
    dr = m_pend & ~v;
    if (dr != 0) m_err = 1'b1;
    if (!m_res) begin
      cand = -1;
      for (int k = 0; k < 4; k++)
        if (cand < 0 && v[(m_ptr + k) % 4]) cand = (m_ptr + k) % 4;
      if (cand >= 0) begin
        if (cst[cand] <= m_credits) begin
          y[cand] = 1'b1; gc = cst[cand]; m_ptr = (cand + 1) % 4;
        end else begin
          m_res = 1'b1; m_resid = cand;
        end
      end
    end else begin
      if (dr[m_resid]) m_res = 1'b0;
      else if (v[m_resid] && cst[m_resid] <= m_credits) begin
        y[m_resid] = 1'b1; gc = cst[m_resid]; m_ptr = (m_resid + 1) % 4; m_res = 1'b0;
      end
    end
    nxt = m_credits - gc + r;
    if (nxt > 10) begin nxt = 10; m_err = 1'b1; end
    m_credits = nxt;
    m_pend    = v & ~y;
  endtask

  // One clock of stimulus: drive, predict, capture grant, then check state.
  task automatic cyc(input logic [3:0] v, input logic [7:0] cost,
                     input logic [1:0] ret, output logic [3:0] y);
    exp_t e;
    exp_t got;
    logic [3:0] y_obs;
    @(negedge clk);
    bus.v_i = v; bus.cost_i = cost; bus.return_i = ret;
    #1;
    model_step(v, cost, ret, y);
    e.yumi = y; e.credits = 4'(m_credits); e.res = m_res; e.err = m_err;
    sb.push_back(e);
    y_obs = bus.yumi_o;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("yumi",     32'(y_obs),    32'(got.yumi));
      chk("credits",  32'(credits),  32'(got.credits));
      chk("reserved", 32'(reserved), 32'(got.res));
      chk("err",      32'(err),      32'(got.err));
    end
  endtask

  // Asserts reset mid-low-phase with the current inputs still applied and
  // checks that outputs respond before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_credits",  32'(credits),    32'd10);
    chk("rst_reserved", 32'(reserved),   32'd0);
    chk("rst_yumi",     32'(bus.yumi_o), 32'd0);
    chk("rst_err",      32'(err),        32'd0);
    bus.v_i = '0; bus.cost_i = '0; bus.return_i = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] y;
    logic [3:0] pend;
    logic [7:0] pcost;
    logic [3:0] v;
    rst_n = 1'b1;
    bus.v_i = 4'b0001; bus.cost_i = '0; bus.return_i = '0;
    model_reset();
    do_reset();

    // Idle: nothing changes
    cyc(4'b0000, 8'h00, 2'd0, y);
    cyc(4'b0000, 8'h00, 2'd0, y);

    // All request cost 1: round-robin 0,1,2,3,... until the pool drains
    for (int i = 0; i < 10; i++) cyc(4'b1111, pk(1,1,1,1), 2'd0, y);
    chk("drain_credits", 32'(credits), 32'd0);
    cyc(4'b1111, pk(1,1,1,1), 2'd0, y);
    chk("drain_reserved", 32'(reserved), 32'd1);
    cyc(4'b1111, pk(1,1,1,1), 2'd1, y);
    cyc(4'b1111, pk(1,1,1,1), 2'd0, y);
    chk("drain_res_grant", 32'(y), 32'b0100);
    do_reset();

    // Bring pool to 1 with ptr back at 0, then reserve on req0
    cyc(4'b0001, pk(2,0,0,0), 2'd0, y);
    cyc(4'b0010, pk(0,2,0,0), 2'd0, y);
    cyc(4'b0100, pk(0,0,2,0), 2'd0, y);
    cyc(4'b1000, pk(0,0,0,2), 2'd0, y);
    cyc(4'b0001, pk(1,0,0,0), 2'd0, y);
    cyc(4'b0010, pk(0,0,0,0), 2'd0, y);
    cyc(4'b0100, pk(0,0,0,0), 2'd0, y);
    cyc(4'b1000, pk(0,0,0,0), 2'd0, y);
    chk("hol_credits1", 32'(credits), 32'd1);
    cyc(4'b0011, pk(2,1,0,0), 2'd0, y);
    chk("hol_reserve", 32'(reserved), 32'd1);
    cyc(4'b0011, pk(2,1,0,0), 2'd1, y);
    chk("hol_blocked", 32'(y), 32'd0);
    cyc(4'b0011, pk(2,1,0,0), 2'd0, y);
    chk("hol_grant0", 32'(y), 32'b0001);
    // ptr is now 1: req1 beats a zero-cost req0 and gets reserved
    cyc(4'b0011, pk(0,1,0,0), 2'd0, y);
    cyc(4'b0011, pk(0,1,0,0), 2'd1, y);
    cyc(4'b0011, pk(0,1,0,0), 2'd0, y);
    chk("hol_grant1", 32'(y), 32'b0010);
    do_reset();

    // Grant and return in the same cycle
    cyc(4'b0001, pk(2,0,0,0), 2'd0, y);
    cyc(4'b0010, pk(0,2,0,0), 2'd0, y);
    cyc(4'b0100, pk(0,0,1,0), 2'd0, y);
    cyc(4'b1000, pk(0,0,0,2), 2'd2, y);
    chk("gr_ret_yumi", 32'(y), 32'b1000);
    chk("gr_ret_credits", 32'(credits), 32'd5);
    do_reset();

    // Return overflow saturates and sets sticky error
    cyc(4'b0000, 8'h00, 2'd1, y);
    chk("ovf_credits", 32'(credits), 32'd10);
    cyc(4'b0000, 8'h00, 2'd0, y);
    chk("ovf_err_sticky", 32'(err), 32'd1);
    do_reset();

    // Oversized cost and oversized return are clamped to 2
    cyc(4'b0001, pk(3,0,0,0), 2'd0, y);
    chk("bigcost_credits", 32'(credits), 32'd8);
    cyc(4'b0000, 8'h00, 2'd3, y);
    chk("bigret_credits", 32'(credits), 32'd10);
    do_reset();

    // Protocol violation: reserved requester drops before grant
    for (int i = 0; i < 5; i++) cyc(4'b0001, pk(2,0,0,0), 2'd0, y);
    cyc(4'b0010, pk(0,1,0,0), 2'd0, y);
    cyc(4'b0000, 8'h00, 2'd0, y);
    chk("drop_err", 32'(err), 32'd1);
    do_reset();

    // Random legal traffic
    pend = '0; pcost = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pcost[2*i +: 2] = 2'($urandom_range(0, 2));
        end
      end
      v = pend;
      cyc(v, pcost, 2'($urandom_range(0, 2)), y);
      pend = pend & ~y;
    end

    // Reset mid-reservation with pool at 1
    do_reset();
    for (int i = 0; i < 4; i++) cyc(4'b0001, pk(2,0,0,0), 2'd0, y);
    cyc(4'b0001, pk(1,0,0,0), 2'd0, y);
    cyc(4'b0010, pk(0,2,0,0), 2'd0, y);
    chk("midres_reserved", 32'(reserved), 32'd1);
    chk("midres_credits", 32'(credits), 32'd1);
    do_reset();
    cyc(4'b0000, 8'h00, 2'd0, y);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
